// File: rtl/lu_serial_sequencer.sv
// Bit-serial front end for an external 1-bit logic unit (NOR/OR/XOR/XNOR).
// Operands are latched on an accepted start. One bit pair per clock is then
// presented to the LU, LSB first. The 1-bit LU results are shifted back in to
// build a WIDTH-bit result word.
module lu_serial_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [1:0]       op_in,
  output logic             lu_a,
  output logic             lu_b,
  output logic [1:0]       lu_op,
  input  logic             lu_result,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [1:0]       op_q;
  logic [CW-1:0]    cnt;

  // LU drive is gated by state, so it reads zero outside SHIFT and after reset.
  assign lu_a  = (state == SHIFT) & a_sh[0];
  assign lu_b  = (state == SHIFT) & b_sh[0];
  assign lu_op = (state == SHIFT) ? op_q : 2'b00;

  // Sequencer FSM: latch on start, shift WIDTH bits, pulse done for one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      op_q   <= 2'b00;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a_in;
            b_sh  <= b_in;
            op_q  <= op_in;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          res_sh <= {lu_result, res_sh[WIDTH-1:1]};
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          cnt    <= cnt + 1'b1;
          // Last bit pair: the word is complete including this cycle's LU bit.
          if (cnt == CW'(WIDTH - 1)) begin
            result <= {lu_result, res_sh[WIDTH-1:1]};
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          // start is deliberately ignored here; busy drops as we leave.
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lu_serial_sequencer.sv
// Directed bench for lu_serial_sequencer (WIDTH=8) with a behavioural
// 1-bit LU attached to the lu_* ports.
module tb_lu_serial_sequencer;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a_in, b_in;
  logic [1:0]       op_in;
  logic             lu_a, lu_b;
  logic [1:0]       lu_op;
  logic             lu_result;
  logic             busy, done;
  logic [WIDTH-1:0] result;

  int errs   = 0;
  int checks = 0;
  logic [WIDTH-1:0] prev_res;

  always #5 clk = ~clk;

  lu_serial_sequencer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a_in(a_in), .b_in(b_in), .op_in(op_in),
    .lu_a(lu_a), .lu_b(lu_b), .lu_op(lu_op), .lu_result(lu_result),
    .busy(busy), .done(done), .result(result)
  );

  // External logic unit: 00 NOR, 01 OR, 10 XOR, 11 XNOR.
  always_comb begin
    lu_result = 1'b0;
    case (lu_op)
      2'b00: lu_result = ~(lu_a | lu_b);
      2'b01: lu_result = lu_a | lu_b;
      2'b10: lu_result = lu_a ^ lu_b;
      2'b11: lu_result = ~(lu_a ^ lu_b);
      default: lu_result = 1'b0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One operation. Edge index i counts posedges after the start edge E0;
  // done must be seen right after E8 and busy for 9 samples (E0..E8).
  // With disturb set, start is re-pulsed and a_in/b_in/op_in are changed mid-SHIFT.
  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] op, input logic [7:0] exp, input bit disturb);
    int bcnt, dcyc, ndone;
    @(negedge clk);
    a_in = a; b_in = b; op_in = op; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bcnt = busy ? 1 : 0; dcyc = 0; ndone = 0;
    for (int i = 1; i <= 14; i++) begin
      @(posedge clk); #1;
      if (busy) bcnt++;
      if (done) begin
        ndone++;
        if (dcyc == 0) dcyc = i;
      end
      if (i == 3) chk({tag, " lu_op"}, 32'(lu_op), 32'(op));
      if (i == 4) chk({tag, " hold"}, 32'(result), 32'(prev_res));
      if (disturb && i == 2) begin
        a_in = 8'h00; b_in = 8'hFF; op_in = ~op; start = 1'b1;
      end
      if (disturb && i == 5) start = 1'b0;
    end
    chk({tag, " done_edge"}, 32'(dcyc), 32'(WIDTH));
    chk({tag, " done_cnt"}, 32'(ndone), 32'd1);
    chk({tag, " busy_cyc"}, 32'(bcnt), 32'(WIDTH + 1));
    chk({tag, " result"}, 32'(result), 32'(exp));
    prev_res = exp;
  endtask

  initial begin
    int last, nd, nd2;
    rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0; op_in = 2'b00;
    prev_res = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst result", 32'(result), 32'd0);
    chk("rst lu", {29'd0, lu_a, lu_b, lu_op[0] | lu_op[1]}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Basic ops on A5/0F, then ordering check.
    do_op("or",   8'hA5, 8'h0F, 2'b01, 8'hAF, 1'b0);
    do_op("xor",  8'hA5, 8'h0F, 2'b10, 8'hAA, 1'b0);
    do_op("nor",  8'hA5, 8'h0F, 2'b00, 8'h50, 1'b0);
    do_op("xnor", 8'hA5, 8'h0F, 2'b11, 8'h55, 1'b0);
    do_op("order", 8'h01, 8'h80, 2'b11, 8'h7E, 1'b0);

    // Disturbance during SHIFT must not affect the latched operation.
    do_op("disturb", 8'hA5, 8'h0F, 2'b01, 8'hAF, 1'b1);

    // start held high: a new op every 10 cycles, each giving FF.
    @(negedge clk);
    a_in = 8'hFF; b_in = 8'h00; op_in = 2'b10; start = 1'b1;
    last = -1; nd = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done) begin
        chk("cont result", 32'(result), 32'hFF);
        if (last >= 0) chk("cont interval", 32'(i - last), 32'd10);
        last = i; nd++;
      end
    end
    start = 1'b0;
    chk("cont ndone", 32'(nd), 32'd3);
    repeat (12) @(posedge clk);

    // Reset during bit 4 of an operation aborts it cleanly.
    @(negedge clk);
    a_in = 8'hA5; b_in = 8'h0F; op_in = 2'b01; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort result", 32'(result), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    nd2 = 0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      if (done) nd2++;
    end
    chk("abort nodone", 32'(nd2), 32'd0);
    prev_res = '0;
    do_op("fresh", 8'hA5, 8'h0F, 2'b10, 8'hAA, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
